// File: rtl/gpi_pad_ctrl_pkg.sv
// Shared types and constants for the GPI pad controller.
// Optional build macro: GPI_CTRL_WAKE_EN (implements CFG bit7 and the WAKE_O output).
package gpi_pad_ctrl_pkg;

   // Pull-change sequencer states; the encoding is visible on DBG_STATE_O.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISOLATE = 3'd1,
      ST_APPLY   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_ENABLE  = 3'd4
   } state_t;

   // Bit positions inside one CFG register.
   localparam int IE_B    = 0;
   localparam int STE_LSB = 1;
   localparam int PD_B    = 3;
   localparam int PU_B    = 4;
   localparam int RISE_B  = 5;
   localparam int FALL_B  = 6;
   localparam int WAKE_B  = 7;

   // Status register addresses, as offsets above the last CFG register (NPADS).
   localparam int PIN_OFS = 0;
   localparam int IRQ_OFS = 1;

   // Cycles the debouncer stays frozen after IE returns, so stale synchroniser bits drain.
   localparam int SYNC_FLUSH = 2;

   typedef struct packed {
      logic       wake_en;
      logic       fall_en;
      logic       rise_en;
      logic       pu;
      logic       pd;
      logic [1:0] ste;
      logic       ie;
   } cfg_t;

   // A pull change needs the isolate/apply/settle/enable sequence.
   function automatic logic pull_changed(input cfg_t a, input cfg_t b);
      return (a.pu != b.pu) || (a.pd != b.pd);
   endfunction

endpackage

// File: rtl/gpi_pad_debounce.sv
// Single-pad input conditioner: 2-flop synchroniser, stability counter, debounced
// level and one-cycle rise/fall strobes that coincide with the PIN update.
// Counting is suspended while the pad is frozen, while IE is low, and for a short
// flush window after both are released.
module gpi_pad_debounce
   import gpi_pad_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic di_i,
   input  logic ie_i,
   input  logic freeze_i,
   output logic pin_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pin_q, pin_d;
   logic [1:0]    hold_q, hold_d;
   logic          stall;

   // Next-state for synchroniser, flush window, stability counter and level.
   always_comb begin
      sync1_d = di_i;
      sync2_d = sync1_q;
      stall   = freeze_i | ~ie_i;
      hold_d  = stall ? 2'(SYNC_FLUSH) : ((hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0);
      cnt_d   = cnt_q;
      pin_d   = pin_q;
      rise_o  = 1'b0;
      fall_o  = 1'b0;
      if (stall || (hold_q != 2'd0) || (sync2_q == pin_q)) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
         cnt_d  = '0;
         pin_d  = sync2_q;
         rise_o = sync2_q;
         fall_o = ~sync2_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Register all per-pad input state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         pin_q   <= 1'b0;
         hold_q  <= 2'd0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         pin_q   <= pin_d;
         hold_q  <= hold_d;
      end
   end

   assign pin_o = pin_q;

endmodule

// File: rtl/gpi_pad_ctrl.sv
// GPI pad bank controller: config register file, glitch-safe pull sequencer,
// per-pad debounce and edge interrupt collection.
// Optional build macro: GPI_CTRL_WAKE_EN (CFG bit7 WAKE_EN and the WAKE_O output).
//
// Config handshake: the master raises CFG_REQ_I with WE/ADDR/WDATA stable and holds
// them until it sees CFG_ACK_O, a single-cycle pulse; read data is valid only while
// CFG_ACK_O is high. A request is accepted only in IDLE and never in the cycle that
// already carries an ack, so a master that drops REQ one cycle late is not serviced
// twice. A pull-changing write completes and acks even if REQ is dropped early.
module gpi_pad_ctrl
   import gpi_pad_ctrl_pkg::*;
#(
   parameter int NPADS         = 8,
   parameter int DEB_CYCLES    = 16,
   parameter int SETTLE_CYCLES = 32,
   parameter int ADDR_W        = $clog2(NPADS + 2)
) (
   input  logic                 CLK_I,
   input  logic                 RST_I,
   input  logic                 CFG_REQ_I,
   input  logic                 CFG_WE_I,
   input  logic [ADDR_W-1:0]    CFG_ADDR_I,
   input  logic [7:0]           CFG_WDATA_I,
   output logic                 CFG_ACK_O,
   output logic [7:0]           CFG_RDATA_O,
   output logic [NPADS-1:0]     IE_O,
   output logic [2*NPADS-1:0]   STE_O,
   output logic [NPADS-1:0]     PD_O,
   output logic [NPADS-1:0]     PU_O,
   input  logic [NPADS-1:0]     DI_I,
   output logic [NPADS-1:0]     PIN_O,
   output logic                 IRQ_O,
`ifdef GPI_CTRL_WAKE_EN
   output logic                 WAKE_O,
`endif
   output logic [2:0]           DBG_STATE_O
);

   localparam int IDX_W = (NPADS > 1) ? $clog2(NPADS) : 1;
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int RD_W  = (NPADS < 8) ? NPADS : 8;
   localparam logic [ADDR_W-1:0] A_PIN = ADDR_W'(NPADS + PIN_OFS);
   localparam logic [ADDR_W-1:0] A_IRQ = ADDR_W'(NPADS + IRQ_OFS);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       seq_idx_q, seq_idx_d;
   cfg_t                   seq_cfg_q, seq_cfg_d;
   logic [SET_W-1:0]       settle_q, settle_d;
   logic                   ack_q, ack_d;
   logic [7:0]             rdata_q, rdata_d;
   cfg_t                   cfg_q [NPADS];
   cfg_t                   cfg_d [NPADS];
   logic [NPADS-1:0]       ie_q, ie_d;
   logic [NPADS-1:0]       pd_q, pd_d;
   logic [NPADS-1:0]       pu_q, pu_d;
   logic [2*NPADS-1:0]     ste_q, ste_d;
   logic [NPADS-1:0]       pend_q, pend_d;

   logic [NPADS-1:0]       pin, rise, fall, freeze, set, clr;
   logic [IDX_W-1:0]       addr_idx;
   logic                   is_cfg;
   cfg_t                   wr_cfg;

   assign addr_idx = CFG_ADDR_I[IDX_W-1:0];
   assign is_cfg   = (CFG_ADDR_I < ADDR_W'(NPADS));

`ifdef GPI_CTRL_WAKE_EN
   assign wr_cfg = cfg_t'(CFG_WDATA_I);
`else
   // Without the wake feature bit7 is never stored.
   logic wdata_unused;
   assign wdata_unused = CFG_WDATA_I[WAKE_B];
   assign wr_cfg       = cfg_t'({1'b0, CFG_WDATA_I[WAKE_B-1:0]});
`endif

   // Per-pad freeze while that pad is being sequenced, and enabled edge flags.
   always_comb begin
      freeze = '0;
      set    = '0;
      for (int i = 0; i < NPADS; i++) begin
         freeze[i] = (state_q != ST_IDLE) && (seq_idx_q == IDX_W'(i));
         set[i]    = (rise[i] & cfg_q[i].rise_en) | (fall[i] & cfg_q[i].fall_en);
      end
   end

   // Register-port decode and pull sequencer next state.
   always_comb begin
      state_d   = state_q;
      seq_idx_d = seq_idx_q;
      seq_cfg_d = seq_cfg_q;
      settle_d  = settle_q;
      ack_d     = 1'b0;
      rdata_d   = '0;
      cfg_d     = cfg_q;
      ie_d      = ie_q;
      pd_d      = pd_q;
      pu_d      = pu_q;
      ste_d     = ste_q;
      clr       = '0;
      case (state_q)
         ST_IDLE: begin
            if (CFG_REQ_I && !ack_q) begin
               ack_d = 1'b1;
               if (is_cfg) begin
                  if (!CFG_WE_I) begin
                     rdata_d = cfg_q[addr_idx];
                  end else if (pull_changed(wr_cfg, cfg_q[addr_idx])) begin
                     ack_d     = 1'b0;
                     state_d   = ST_ISOLATE;
                     seq_idx_d = addr_idx;
                     seq_cfg_d = wr_cfg;
                  end else begin
                     cfg_d[addr_idx]                = wr_cfg;
                     ie_d[addr_idx]                 = wr_cfg.ie;
                     ste_d[{addr_idx, 1'b0} +: 2]   = wr_cfg.ste;
                  end
               end else if (CFG_ADDR_I == A_PIN) begin
                  if (!CFG_WE_I) rdata_d[RD_W-1:0] = pin[RD_W-1:0];
               end else if (CFG_ADDR_I == A_IRQ) begin
                  if (CFG_WE_I) clr[RD_W-1:0] = CFG_WDATA_I[RD_W-1:0];
                  else          rdata_d[RD_W-1:0] = pend_q[RD_W-1:0];
               end
            end
         end
         ST_ISOLATE: begin
            ie_d[seq_idx_q] = 1'b0;
            state_d         = ST_APPLY;
         end
         ST_APPLY: begin
            pu_d[seq_idx_q]               = seq_cfg_q.pu;
            pd_d[seq_idx_q]               = seq_cfg_q.pd;
            ste_d[{seq_idx_q, 1'b0} +: 2] = seq_cfg_q.ste;
            settle_d                      = SET_W'(SETTLE_CYCLES - 1);
            state_d                       = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == '0) state_d = ST_ENABLE;
            else                settle_d = settle_q - SET_W'(1);
         end
         ST_ENABLE: begin
            ie_d[seq_idx_q]  = seq_cfg_q.ie;
            cfg_d[seq_idx_q] = seq_cfg_q;
            ack_d            = 1'b1;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A new edge wins over a simultaneous write-1-to-clear.
      pend_d = (pend_q & ~clr) | set;
   end

   // Controller state, register file, pad outputs and pending flags.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q   <= ST_IDLE;
         seq_idx_q <= '0;
         seq_cfg_q <= '0;
         settle_q  <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         for (int i = 0; i < NPADS; i++) cfg_q[i] <= '0;
         ie_q      <= '0;
         pd_q      <= '0;
         pu_q      <= '0;
         ste_q     <= '0;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         seq_idx_q <= seq_idx_d;
         seq_cfg_q <= seq_cfg_d;
         settle_q  <= settle_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         cfg_q     <= cfg_d;
         ie_q      <= ie_d;
         pd_q      <= pd_d;
         pu_q      <= pu_d;
         ste_q     <= ste_d;
         pend_q    <= pend_d;
      end
   end

   for (genvar g = 0; g < NPADS; g++) begin : g_pad
      gpi_pad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk_i    (CLK_I),
         .rst_i    (RST_I),
         .di_i     (DI_I[g]),
         .ie_i     (ie_q[g]),
         .freeze_i (freeze[g]),
         .pin_o    (pin[g]),
         .rise_o   (rise[g]),
         .fall_o   (fall[g])
      );
   end

`ifdef GPI_CTRL_WAKE_EN
   logic [NPADS-1:0] wake_en;

   // Gather WAKE_EN bits; the wake path itself uses the raw pad input so it works unclocked.
   always_comb begin
      wake_en = '0;
      for (int i = 0; i < NPADS; i++) wake_en[i] = cfg_q[i].wake_en;
   end

   assign WAKE_O = |(wake_en & ie_q & (DI_I ^ pin));
`endif

   assign CFG_ACK_O   = ack_q;
   assign CFG_RDATA_O = rdata_q;
   assign IE_O        = ie_q;
   assign STE_O       = ste_q;
   assign PD_O        = pd_q;
   assign PU_O        = pu_q;
   assign PIN_O       = pin;
   assign IRQ_O       = |pend_q;
   assign DBG_STATE_O = state_q;

endmodule

// File: tb/tb_gpi_pad_ctrl.sv
// Bench for gpi_pad_ctrl with default parameters (NPADS=8, DEB_CYCLES=16,
// SETTLE_CYCLES=32). Optional build macro: GPI_CTRL_WAKE_EN.
module tb_gpi_pad_ctrl;
   import gpi_pad_ctrl_pkg::*;

   localparam int NPADS  = 8;
   localparam int DEB    = 16;
   localparam int SETTLE = 32;
   localparam int AW     = 4;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic clk_en = 1'b1;
   logic rst    = 1'b1;

   always #5 if (clk_en) clk = ~clk;

   logic                req   = 1'b0;
   logic                we    = 1'b0;
   logic [AW-1:0]       addr  = '0;
   logic [7:0]          wdata = '0;
   logic [NPADS-1:0]    di    = '0;
   logic                ack;
   logic [7:0]          rdata;
   logic [NPADS-1:0]    ie, pd, pu, pin;
   logic [2*NPADS-1:0]  ste;
   logic                irq;
   logic [2:0]          dbg;
`ifdef GPI_CTRL_WAKE_EN
   logic                wake;
`endif

   logic [7:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   gpi_pad_ctrl #(.NPADS(NPADS), .DEB_CYCLES(DEB), .SETTLE_CYCLES(SETTLE)) dut (
      .CLK_I       (clk),
      .RST_I       (rst),
      .CFG_REQ_I   (req),
      .CFG_WE_I    (we),
      .CFG_ADDR_I  (addr),
      .CFG_WDATA_I (wdata),
      .CFG_ACK_O   (ack),
      .CFG_RDATA_O (rdata),
      .IE_O        (ie),
      .STE_O       (ste),
      .PD_O        (pd),
      .PU_O        (pu),
      .DI_I        (di),
      .PIN_O       (pin),
      .IRQ_O       (irq),
`ifdef GPI_CTRL_WAKE_EN
      .WAKE_O      (wake),
`endif
      .DBG_STATE_O (dbg)
   );

   // ---------------- driver ----------------
   // One config transaction; reads pop the scoreboard when the ack arrives.
   task automatic cfg_xact(input logic w, input logic [AW-1:0] a, input logic [7:0] d,
                           output int lat);
      logic [7:0] exp;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (ack) break;
      end
      req = 1'b0;
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL ack_timeout addr=%0d: no ack after %0d cycles", a, lat);
         if (!w && exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (!w) begin
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         checks++;
         if (rdata !== exp) begin
            errors++;
            $display("FAIL read_addr%0d: got %02h expected %02h", a, rdata, exp);
         end
      end
   endtask

   task automatic read_expect(input logic [AW-1:0] a, input logic [7:0] exp);
      int lat;
      exp_q.push_back(exp);
      cfg_xact(1'b0, a, 8'h00, lat);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({ie, ste, pd, pu, pin, irq, ack, dbg} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ie=%h ste=%h pd=%h pu=%h pin=%h irq=%b ack=%b st=%0d expected all 0",
                  ie, ste, pd, pu, pin, irq, ack, dbg);
      end
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 4'd2; wdata = 8'h19;
      repeat (10) @(negedge clk);
      checks++;
      if (dbg !== 3'(ST_SETTLE) || pu[2] !== 1'b1 || pd[2] !== 1'b1 || ie[2] !== 1'b0) begin
         errors++;
         $display("FAIL mid_settle: st=%0d pu2=%b pd2=%b ie2=%b expected st=3 pu2=1 pd2=1 ie2=0",
                  dbg, pu[2], pd[2], ie[2]);
      end
      #2 rst = 1'b1; req = 1'b0;
      #1;
      checks++;
      if ({ie, pu, pd, irq, ack, dbg} !== '0) begin
         errors++;
         $display("FAIL reset_mid_seq: ie=%h pu=%h pd=%h irq=%b ack=%b st=%0d expected all 0",
                  ie, pu, pd, irq, ack, dbg);
      end
      @(negedge clk);
      rst = 1'b0;
      read_expect(4'd2, 8'h00);
   endtask

   task automatic test_fast_write();
      int lat;
      cfg_xact(1'b1, 4'd6, 8'h07, lat);
      checks++;
      if (lat !== 1 || ie[6] !== 1'b1 || ste[13:12] !== 2'b11 || pu[6] !== 1'b0 || pd[6] !== 1'b0) begin
         errors++;
         $display("FAIL fast_write: lat=%0d ie6=%b ste6=%b pu6=%b pd6=%b expected 1 1 11 0 0",
                  lat, ie[6], ste[13:12], pu[6], pd[6]);
      end
      read_expect(4'd6, 8'h07);
      cfg_xact(1'b1, 4'd6, 8'h00, lat);
      checks++;
      if (lat !== 1 || ie[6] !== 1'b0 || ste[13:12] !== 2'b00) begin
         errors++;
         $display("FAIL fast_clear: lat=%0d ie6=%b ste6=%b expected 1 0 00", lat, ie[6], ste[13:12]);
      end
   endtask

   task automatic test_pull_seq();
      int pu_cyc, ie_cyc, ack_cyc;
      pu_cyc = -1; ie_cyc = -1; ack_cyc = -1;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 4'd1; wdata = 8'h11;
      for (int c = 1; c <= 60 && ack_cyc < 0; c++) begin
         @(negedge clk);
         if (pu[1] && pu_cyc < 0) pu_cyc = c;
         if (ie[1] && ie_cyc < 0) ie_cyc = c;
         if (ack) begin ack_cyc = c; req = 1'b0; end
      end
      req = 1'b0;
      checks++;
      if (pu_cyc !== 3) begin
         errors++;
         $display("FAIL pull_apply_cycle: got %0d expected 3", pu_cyc);
      end
      checks++;
      if (ie_cyc !== SETTLE + 4) begin
         errors++;
         $display("FAIL ie_enable_cycle: got %0d expected %0d", ie_cyc, SETTLE + 4);
      end
      checks++;
      if (ack_cyc !== SETTLE + 4) begin
         errors++;
         $display("FAIL pull_ack_cycle: got %0d expected %0d", ack_cyc, SETTLE + 4);
      end
      read_expect(4'd1, 8'h11);
   endtask

   task automatic test_debounce();
      int lat, cyc;
      logic seen;
      cfg_xact(1'b1, 4'd0, 8'h01, lat);
      checks++;
      if (lat !== 1 || ie[0] !== 1'b1) begin
         errors++;
         $display("FAIL ie0_write: lat=%0d ie0=%b expected 1 1", lat, ie[0]);
      end
      repeat (5) @(negedge clk);
      seen = 1'b0;
      di[0] = 1'b1;
      repeat (10) begin @(negedge clk); if (pin[0]) seen = 1'b1; end
      di[0] = 1'b0;
      repeat (30) begin @(negedge clk); if (pin[0]) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL glitch_filtered: pin0 rose=%b expected 0", seen);
      end
      di[0] = 1'b1;
      cyc = 0;
      while (cyc < 40 && !pin[0]) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== DEB + 2) begin
         errors++;
         $display("FAIL debounce_rise_latency: got %0d expected %0d", cyc, DEB + 2);
      end
      read_expect(4'(NPADS), 8'h01);
      di[0] = 1'b0;
      cyc = 0;
      while (cyc < 40 && pin[0]) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== DEB + 2) begin
         errors++;
         $display("FAIL debounce_fall_latency: got %0d expected %0d", cyc, DEB + 2);
      end
   endtask

   task automatic test_edge_irq();
      int lat;
      cfg_xact(1'b1, 4'd3, 8'h61, lat);
      repeat (5) @(negedge clk);
      di[3] = 1'b1;
      repeat (25) @(negedge clk);
      di[3] = 1'b0;
      repeat (25) @(negedge clk);
      checks++;
      if (pin[3] !== 1'b0 || irq !== 1'b1) begin
         errors++;
         $display("FAIL edge_irq: pin3=%b irq=%b expected 0 1", pin[3], irq);
      end
      read_expect(4'(NPADS + 1), 8'h08);
      cfg_xact(1'b1, 4'(NPADS + 1), 8'h08, lat);
      read_expect(4'(NPADS + 1), 8'h00);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_irq: irq=%b expected 0", irq);
      end
      // Time the clear so it lands on the same edge that raises PIN_O[3].
      di[3] = 1'b1;
      repeat (DEB + 1) @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 4'(NPADS + 1); wdata = 8'h08;
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (ack !== 1'b1 || pin[3] !== 1'b1) begin
         errors++;
         $display("FAIL w1c_collision_align: ack=%b pin3=%b expected 1 1", ack, pin[3]);
      end
      read_expect(4'(NPADS + 1), 8'h08);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL set_beats_clear: irq=%b expected 1", irq);
      end
   endtask

   task automatic test_back_to_back();
      int lat, wr_ack, rd_ack;
      logic [7:0] exp;
      wr_ack = -1; rd_ack = -1;
      exp_q.push_back(8'h08);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'h09;
      for (int c = 1; c <= 80 && rd_ack < 0; c++) begin
         @(negedge clk);
         if (c == 2) req = 1'b0;
         if (c == 4) begin req = 1'b1; we = 1'b0; addr = 4'(NPADS); end
         if (ack) begin
            if (wr_ack < 0) begin
               wr_ack = c;
            end else begin
               rd_ack = c;
               req = 1'b0;
               exp = exp_q.pop_front();
               checks++;
               if (rdata !== exp) begin
                  errors++;
                  $display("FAIL pin_read_after_seq: got %02h expected %02h", rdata, exp);
               end
            end
         end
      end
      req = 1'b0;
      checks++;
      if (wr_ack !== SETTLE + 4) begin
         errors++;
         $display("FAIL dropped_req_ack: got %0d expected %0d", wr_ack, SETTLE + 4);
      end
      checks++;
      if (rd_ack <= wr_ack || rd_ack > wr_ack + 2) begin
         errors++;
         $display("FAIL read_after_seq: read ack %0d write ack %0d expected 1..2 cycles later", rd_ack, wr_ack);
      end
      checks++;
      if (ie[5] !== 1'b1 || pd[5] !== 1'b1 || pu[5] !== 1'b0) begin
         errors++;
         $display("FAIL pad5_outputs: ie=%b pd=%b pu=%b expected 1 1 0", ie[5], pd[5], pu[5]);
      end
      read_expect(4'd5, 8'h09);
      read_expect(4'(NPADS + 2), 8'h00);
      cfg_xact(1'b1, 4'(NPADS + 2), 8'hff, lat);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL unmapped_write_ack: latency %0d expected 1", lat);
      end
      read_expect(4'd15, 8'h00);
   endtask

   task automatic test_wake_bit7();
      int lat;
      cfg_xact(1'b1, 4'd0, 8'h81, lat);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL bit7_write_latency: got %0d expected 1", lat);
      end
`ifdef GPI_CTRL_WAKE_EN
      read_expect(4'd0, 8'h81);
      @(negedge clk);
      clk_en = 1'b0;
      #1;
      checks++;
      if (wake !== 1'b0) begin
         errors++;
         $display("FAIL wake_idle: wake=%b expected 0", wake);
      end
      di[0] = 1'b1;
      #2;
      checks++;
      if (wake !== 1'b1) begin
         errors++;
         $display("FAIL wake_unclocked: wake=%b expected 1", wake);
      end
      di[0] = 1'b0;
      #2;
      checks++;
      if (wake !== 1'b0) begin
         errors++;
         $display("FAIL wake_release: wake=%b expected 0", wake);
      end
      clk_en = 1'b1;
`else
      read_expect(4'd0, 8'h01);
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_fast_write();
      test_pull_seq();
      test_debounce();
      test_edge_irq();
      test_back_to_back();
      test_wake_bit7();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
